int_prod_mac: RTL and testbench

INT_PROD_MAC -- requirements
Module: intProd_M

---
 rtl/int_prod_mac_if.sv | 14 +
 rtl/int_prod_mac.sv | 63 ++++++
 tb/tb_int_prod_mac.sv | 139 +++++++++++++
 3 files changed

// File: rtl/int_prod_mac_if.sv
// int_prod_mac_if: vector-pair input and registered result bundle for int_prod_mac
interface int_prod_mac_if #(
    parameter int N_ELEM = 5,
    parameter int ELEM_W = 8
);
    logic                       in_valid;
    logic [N_ELEM*ELEM_W-1:0]   lin;
    logic [N_ELEM*ELEM_W-1:0]   col;
    logic [ELEM_W-1:0]          n_out;
    logic                       ovf;
    logic                       out_valid;
    modport master (output in_valid, lin, col, input n_out, ovf, out_valid);
    modport slave  (input in_valid, lin, col, output n_out, ovf, out_valid);
endinterface

// File: rtl/int_prod_mac.sv
// int_prod_mac: two-stage signed inner product of two packed vectors with wrap result and overflow flag
module int_prod_mac #(
    parameter int N_ELEM = 5,
    parameter int ELEM_W = 8
) (
    input logic            clk,
    input logic            rst,
    int_prod_mac_if.slave  bus
);
    localparam int PW = 2 * ELEM_W;
    localparam int SW = PW + $clog2(N_ELEM) + 1;

    logic [PW-1:0]        mul  [N_ELEM];
    logic [PW-1:0]        prod [N_ELEM];
    logic                 v1;
    logic [SW-1:0]        sum;
    logic [SW-ELEM_W:0]   top;
    logic                 ovf_c;

    function automatic logic [PW-1:0] sx(input logic [ELEM_W-1:0] x);
        return {{ELEM_W{x[ELEM_W-1]}}, x};
    endfunction

    // element 1 sits in the most significant slot
    always_comb begin
        for (int i = 0; i < N_ELEM; i++)
            mul[i] = sx(bus.lin[(N_ELEM-1-i)*ELEM_W +: ELEM_W]) * sx(bus.col[(N_ELEM-1-i)*ELEM_W +: ELEM_W]);
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_ELEM; i++)
            sum = sum + {{(SW-PW){prod[i][PW-1]}}, prod[i]};
        top = sum[SW-1:ELEM_W-1];
        ovf_c = !((&top) || (~|top));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            for (int i = 0; i < N_ELEM; i++)
                prod[i] <= '0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid)
                prod <= mul;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.n_out     <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            bus.out_valid <= v1;
            if (v1) begin
                bus.n_out <= sum[ELEM_W-1:0];
                bus.ovf   <= ovf_c;
            end
        end
    end
endmodule

// File: tb/tb_int_prod_mac.sv
// tb_int_prod_mac: directed table and sequence checks for int_prod_mac
module tb_int_prod_mac;
    logic clk;
    logic rst;
    int n_tests;
    int n_fail;

    int_prod_mac_if #(.N_ELEM(5), .ELEM_W(8)) bif ();
    int_prod_mac #(.N_ELEM(5), .ELEM_W(8)) dut (.clk(clk), .rst(rst), .bus(bif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] lin;
        logic [39:0] col;
        logic [7:0]  exp_n;
        logic        exp_ovf;
        string       name;
    } vec_t;

    vec_t tbl [12];
    logic [7:0] last_n;
    logic       last_ovf;

    function automatic logic [39:0] p5(input int a, input int b, input int c, input int d, input int e);
        logic [31:0] ua, ub, uc, ud, ue;
        ua = a; ub = b; uc = c; ud = d; ue = e;
        return {ua[7:0], ub[7:0], uc[7:0], ud[7:0], ue[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [39:0] l, input logic [39:0] c);
        bif.in_valid = v;
        bif.lin = l;
        bif.col = c;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        tbl[0]  = '{p5(1,2,3,4,5),           p5(1,1,1,1,1),           8'h0F, 1'b0, "sum15"};
        tbl[1]  = '{p5(-1,-2,-3,-4,-5),      p5(2,2,2,2,2),           8'hE2, 1'b0, "neg30"};
        tbl[2]  = '{p5(127,0,0,0,0),         p5(1,1,0,0,0),           8'h7F, 1'b0, "max127"};
        tbl[3]  = '{p5(64,64,0,0,0),         p5(1,1,0,0,0),           8'h80, 1'b1, "pos128"};
        tbl[4]  = '{p5(-128,0,0,0,0),        p5(1,1,0,0,0),           8'h80, 1'b0, "min128"};
        tbl[5]  = '{p5(-128,-1,0,0,0),       p5(1,1,0,0,0),           8'h7F, 1'b1, "neg129"};
        tbl[6]  = '{p5(10,10,10,10,10),      p5(10,10,10,10,10),      8'hF4, 1'b1, "s500"};
        tbl[7]  = '{p5(-128,-128,-128,-128,-128), p5(-128,-128,-128,-128,-128), 8'h00, 1'b1, "s81920"};
        tbl[8]  = '{p5(3,-7,20,-1,100),      p5(5,2,-3,9,1),          8'h20, 1'b0, "mix32"};
        tbl[9]  = '{p5(127,127,127,127,127), p5(127,127,127,127,127), 8'h05, 1'b1, "s80645"};
        tbl[10] = '{p5(-128,-128,-128,-128,-128), p5(127,127,127,127,127), 8'h80, 1'b1, "sm81280"};
        tbl[11] = '{p5(-100,50,0,0,0),       p5(2,1,0,0,0),           8'h6A, 1'b1, "sm150"};

        drive(1'b0, '0, '0);
        rst = 1'b0;
        #1;
        chk("rst_n_out", {24'd0, bif.n_out}, 32'd0);
        chk("rst_ovf", {31'd0, bif.ovf}, 32'd0);
        chk("rst_valid", {31'd0, bif.out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            drive(1'b1, tbl[i].lin, tbl[i].col);
            @(negedge clk);
            drive(1'b0, '0, '0);
            chk({tbl[i].name, "_early"}, {31'd0, bif.out_valid}, 32'd0);
            @(negedge clk);
            chk({tbl[i].name, "_valid"}, {31'd0, bif.out_valid}, 32'd1);
            chk({tbl[i].name, "_n"}, {24'd0, bif.n_out}, {24'd0, tbl[i].exp_n});
            chk({tbl[i].name, "_ovf"}, {31'd0, bif.ovf}, {31'd0, tbl[i].exp_ovf});
        end

        // back-to-back: vectors 6..10 on consecutive cycles
        for (int c = 0; c < 8; c++) begin
            if (c >= 2 && c < 7) begin
                chk("b2b_valid", {31'd0, bif.out_valid}, 32'd1);
                chk("b2b_n", {24'd0, bif.n_out}, {24'd0, tbl[c+4].exp_n});
                chk("b2b_ovf", {31'd0, bif.ovf}, {31'd0, tbl[c+4].exp_ovf});
            end
            if (c < 5) drive(1'b1, tbl[c+6].lin, tbl[c+6].col);
            else drive(1'b0, tbl[1].lin, tbl[1].col);
            @(negedge clk);
        end
        last_n = tbl[10].exp_n;
        last_ovf = tbl[10].exp_ovf;

        // idle gap holds last result
        for (int c = 0; c < 3; c++) begin
            chk("gap_valid", {31'd0, bif.out_valid}, 32'd0);
            chk("gap_n", {24'd0, bif.n_out}, {24'd0, last_n});
            chk("gap_ovf", {31'd0, bif.ovf}, {31'd0, last_ovf});
            @(negedge clk);
        end

        // reset mid-cycle with pairs in flight
        drive(1'b1, tbl[0].lin, tbl[0].col);
        @(negedge clk);
        drive(1'b1, tbl[1].lin, tbl[1].col);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_n_out", {24'd0, bif.n_out}, 32'd0);
        chk("arst_ovf", {31'd0, bif.ovf}, 32'd0);
        chk("arst_valid", {31'd0, bif.out_valid}, 32'd0);
        drive(1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, bif.out_valid}, 32'd0);
            chk("post_rst_n", {24'd0, bif.n_out}, 32'd0);
        end

        // first pair after reset keeps the two-edge latency
        drive(1'b1, tbl[5].lin, tbl[5].col);
        @(negedge clk);
        drive(1'b0, '0, '0);
        chk("first_early", {31'd0, bif.out_valid}, 32'd0);
        @(negedge clk);
        chk("first_valid", {31'd0, bif.out_valid}, 32'd1);
        chk("first_n", {24'd0, bif.n_out}, {24'd0, tbl[5].exp_n});
        chk("first_ovf", {31'd0, bif.ovf}, {31'd0, tbl[5].exp_ovf});
        @(negedge clk);
        chk("first_drop", {31'd0, bif.out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
